// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button front-end (btn_conditioner).
// Button identifiers are ordered by arbitration priority: lower value wins.
package btn_pkg;

  localparam int NUM_BTN = 4;

  typedef enum logic [1:0] {
    BTN_IZQ = 2'd0,
    BTN_DER = 2'd1,
    BTN_ARR = 2'd2,
    BTN_ABA = 2'd3
  } btn_id_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    HOLD   = 2'd2,
    REPEAT = 2'd3
  } state_t;

  // Largest of three cycle counts; sizes the shared counter width.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/btn_if.sv
// Pad/strobe bundle between the board pins and the movement FSM.
// Protocol: raw pads are active-low and fully asynchronous. Each strobe
// output is active-low, lasts exactly one clock and is never asserted
// together with another strobe; there is no back-pressure, the consumer
// must act on the strobe in the cycle it is low. btn_active is high while
// the accepted button is still held. state_dbg mirrors the arbiter state.
interface btn_if;
  import btn_pkg::*;

  logic   btn_izquierda_raw;
  logic   btn_derecha_raw;
  logic   btn_arriba_raw;
  logic   btn_abajo_raw;
  logic   btn_izquierda;
  logic   btn_derecha;
  logic   btn_arriba;
  logic   btn_abajo;
  logic   btn_active;
  state_t state_dbg;

  // Board / stimulus side: drives pads, observes strobes.
  modport master (
    output btn_izquierda_raw, btn_derecha_raw, btn_arriba_raw, btn_abajo_raw,
    input  btn_izquierda, btn_derecha, btn_arriba, btn_abajo, btn_active,
    input  state_dbg
  );

  // Conditioner side: reads pads, produces strobes.
  modport slave (
    input  btn_izquierda_raw, btn_derecha_raw, btn_arriba_raw, btn_abajo_raw,
    output btn_izquierda, btn_derecha, btn_arriba, btn_abajo, btn_active,
    output state_dbg
  );
endinterface

// File: rtl/btn_debounce.sv
// One button lane: pad synchroniser, stability-counting debouncer and
// press/release event detection. Released level is 1 (pads are active-low).
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CW              = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_evt,
  output logic rel_evt
);

  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   sample;

  assign sample = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; resets to the released level so no false press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      level     <= 1'b1;
      press_evt <= 1'b0;
      rel_evt   <= 1'b0;
    end else begin
      press_evt <= 1'b0;
      rel_evt   <= 1'b0;
      if (sample == level) begin
        cnt_q <= '0;
      end else if (cnt_q == DEB_LAST) begin
        level     <= sample;
        cnt_q     <= '0;
        press_evt <= ~sample;
        rel_evt   <= sample;
      end else if (cnt_q != CNT_SAT) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Four-button front-end: per-button debounce lanes feeding a shared
// arbiter that emits one active-low, one-cycle strobe per accepted press.
// Optional auto-repeat while held: define BTN_CONDITIONER_AUTOREPEAT_EN.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic  clk,
  input  logic  rst,
  btn_if.slave  bus
);

  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [NUM_BTN-1:0] raw_v;
  logic [NUM_BTN-1:0] lvl;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] rel_v;

  // Index order follows btn_id_t so bit 0 is the highest priority.
  assign raw_v = {bus.btn_abajo_raw, bus.btn_arriba_raw,
                  bus.btn_derecha_raw, bus.btn_izquierda_raw};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
    btn_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CW              (CW)
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .raw       (raw_v[g]),
      .level     (lvl[g]),
      .press_evt (press[g]),
      .rel_evt   (rel_v[g])
    );
  end

  state_t             state_q, state_d;
  btn_id_t            win_q, win_d, win_pick;
  logic               fire;
  logic               rel_win;
  logic               active_d;
  logic               active_q;
  logic [NUM_BTN-1:0] out_q;

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] RPT_SAT     = {CW{1'b1}};
  logic [CW-1:0] rpt_q, rpt_d;
`endif

  // Fixed priority among same-cycle presses; losers are simply dropped.
  always_comb begin
    win_pick = BTN_IZQ;
    if      (press[BTN_IZQ]) win_pick = BTN_IZQ;
    else if (press[BTN_DER]) win_pick = BTN_DER;
    else if (press[BTN_ARR]) win_pick = BTN_ARR;
    else if (press[BTN_ABA]) win_pick = BTN_ABA;
  end

  // Latched button counts as released once its debounced level is back high.
  assign rel_win = lvl[win_q] | rel_v[win_q];

  // Arbiter next-state; fire requests a strobe of the latched button next cycle.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    fire    = 1'b0;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    rpt_d   = rpt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|press) begin
          win_d   = win_pick;
          state_d = PULSE;
        end
      end
      PULSE: begin
        fire    = 1'b1;
        state_d = rel_win ? IDLE : HOLD;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
        rpt_d   = '0;
`endif
      end
      HOLD: begin
        if (rel_win) begin
          state_d = IDLE;
        end
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
        else if (rpt_q == DELAY_LAST) begin
          fire    = 1'b1;
          state_d = REPEAT;
          rpt_d   = '0;
        end else if (rpt_q != RPT_SAT) begin
          rpt_d = rpt_q + CW'(1);
        end
`endif
      end
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
      REPEAT: begin
        if (rel_win) begin
          state_d = IDLE;
        end else if (rpt_q == PERIOD_LAST) begin
          fire  = 1'b1;
          rpt_d = '0;
        end else if (rpt_q != RPT_SAT) begin
          rpt_d = rpt_q + CW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // btn_active rises the cycle after PULSE and drops on the release edge.
  assign active_d = ((state_q == HOLD) || (state_q == REPEAT)) && !rel_win;

  // Arbiter state, winner latch and registered active-low outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      win_q    <= BTN_IZQ;
      out_q    <= '1;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      out_q    <= fire ? ~(NUM_BTN'(1) << win_q) : '1;
      active_q <= active_d;
    end
  end

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
  // Hold/repeat interval counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rpt_q <= '0;
    else     rpt_q <= rpt_d;
  end
`endif

  assign bus.btn_izquierda = out_q[BTN_IZQ];
  assign bus.btn_derecha   = out_q[BTN_DER];
  assign bus.btn_arriba    = out_q[BTN_ARR];
  assign bus.btn_abajo     = out_q[BTN_ABA];
  assign bus.btn_active    = active_q;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat settings.
// Cycle k of a scenario is the period following the k-th rising edge after
// the pad change; strobe positions below are hand-derived from that origin.
module tb_btn_conditioner;
  import btn_pkg::*;

  logic clk;
  logic rst;
  int   n_asserts;
  int   n_fails;

  btn_if bus ();

  btn_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] outs();
    return {bus.btn_abajo, bus.btn_arriba, bus.btn_derecha, bus.btn_izquierda};
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] o;
    rst = 1'b1;
    bus.btn_izquierda_raw = 1'b1;
    bus.btn_derecha_raw   = 1'b1;
    bus.btn_arriba_raw    = 1'b1;
    bus.btn_abajo_raw     = 1'b1;
    #2;
    o = outs();
    n_asserts++;
    if (o !== 4'b1111) begin
      n_fails++;
      $display("FAIL reset_outs: got %b expected 1111", o);
    end
    n_asserts++;
    if (bus.btn_active !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_active: got %b expected 0", bus.btn_active);
    end
    tick();
    tick();
    n_asserts++;
    if (bus.state_dbg !== IDLE) begin
      n_fails++;
      $display("FAIL reset_state: got %0d expected %0d", bus.state_dbg, IDLE);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      o = outs();
      n_asserts++;
      if (o !== 4'b1111 || bus.btn_active !== 1'b0) begin
        n_fails++;
        $display("FAIL idle_quiet k=%0d: got outs=%b active=%b expected outs=1111 active=0",
                 k, o, bus.btn_active);
      end
    end
  endtask

  task automatic test_press_release();
    logic [3:0] o;
    logic [3:0] exp_o;
    logic       exp_a;
    bus.btn_izquierda_raw = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      tick();
      o     = outs();
      exp_o = (k == 7) ? 4'b1110 : 4'b1111;
      exp_a = (k >= 8);
      n_asserts++;
      if (o !== exp_o || bus.btn_active !== exp_a) begin
        n_fails++;
        $display("FAIL izq_press k=%0d: got outs=%b active=%b expected outs=%b active=%b",
                 k, o, bus.btn_active, exp_o, exp_a);
      end
    end
    bus.btn_izquierda_raw = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      o     = outs();
      exp_a = (k < 6);
      n_asserts++;
      if (o !== 4'b1111 || bus.btn_active !== exp_a) begin
        n_fails++;
        $display("FAIL izq_release k=%0d: got outs=%b active=%b expected outs=1111 active=%b",
                 k, o, bus.btn_active, exp_a);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] o;
    logic [3:0] exp_o;
    logic       exp_a;
    for (int i = 0; i < 30; i++) begin
      bus.btn_arriba_raw = (i < 20) ? (((i / 2) % 2) == 1) : 1'b1;
      tick();
      o = outs();
      n_asserts++;
      if (o !== 4'b1111 || bus.btn_active !== 1'b0) begin
        n_fails++;
        $display("FAIL bounce_quiet i=%0d: got outs=%b active=%b expected outs=1111 active=0",
                 i, o, bus.btn_active);
      end
    end
    bus.btn_arriba_raw = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      tick();
      o     = outs();
      exp_o = (k == 7) ? 4'b1011 : 4'b1111;
      exp_a = (k >= 8);
      n_asserts++;
      if (o !== exp_o || bus.btn_active !== exp_a) begin
        n_fails++;
        $display("FAIL arr_press k=%0d: got outs=%b active=%b expected outs=%b active=%b",
                 k, o, bus.btn_active, exp_o, exp_a);
      end
    end
    bus.btn_arriba_raw = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      o     = outs();
      exp_a = (k < 6);
      n_asserts++;
      if (o !== 4'b1111 || bus.btn_active !== exp_a) begin
        n_fails++;
        $display("FAIL arr_release k=%0d: got outs=%b active=%b expected outs=1111 active=%b",
                 k, o, bus.btn_active, exp_a);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] o;
    logic [3:0] exp_o;
    logic       exp_a;
    bus.btn_derecha_raw = 1'b0;
    bus.btn_abajo_raw   = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      tick();
      o     = outs();
      exp_o = (k == 7) ? 4'b1101 : 4'b1111;
      exp_a = (k >= 8);
      n_asserts++;
      if (o !== exp_o || bus.btn_active !== exp_a) begin
        n_fails++;
        $display("FAIL simul_press k=%0d: got outs=%b active=%b expected outs=%b active=%b",
                 k, o, bus.btn_active, exp_o, exp_a);
      end
    end
    bus.btn_derecha_raw = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      o     = outs();
      exp_a = (k < 6);
      n_asserts++;
      if (o !== 4'b1111 || bus.btn_active !== exp_a) begin
        n_fails++;
        $display("FAIL simul_dropped k=%0d: got outs=%b active=%b expected outs=1111 active=%b",
                 k, o, bus.btn_active, exp_a);
      end
    end
    bus.btn_abajo_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      o = outs();
      n_asserts++;
      if (o !== 4'b1111 || bus.btn_active !== 1'b0) begin
        n_fails++;
        $display("FAIL simul_settle k=%0d: got outs=%b active=%b expected outs=1111 active=0",
                 k, o, bus.btn_active);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [3:0] o;
    logic [3:0] exp_o;
    logic       exp_a;
    bus.btn_abajo_raw = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      tick();
      o     = outs();
      exp_o = (k == 7) ? 4'b0111 : 4'b1111;
      exp_a = (k >= 8);
      n_asserts++;
      if (o !== exp_o || bus.btn_active !== exp_a) begin
        n_fails++;
        $display("FAIL aba_press k=%0d: got outs=%b active=%b expected outs=%b active=%b",
                 k, o, bus.btn_active, exp_o, exp_a);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    o = outs();
    n_asserts++;
    if (o !== 4'b1111 || bus.btn_active !== 1'b0 || bus.state_dbg !== IDLE) begin
      n_fails++;
      $display("FAIL async_reset: got outs=%b active=%b state=%0d expected outs=1111 active=0 state=0",
               o, bus.btn_active, bus.state_dbg);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      tick();
      o     = outs();
      exp_o = (k == 7) ? 4'b0111 : 4'b1111;
      exp_a = (k >= 8);
      n_asserts++;
      if (o !== exp_o || bus.btn_active !== exp_a) begin
        n_fails++;
        $display("FAIL aba_after_reset k=%0d: got outs=%b active=%b expected outs=%b active=%b",
                 k, o, bus.btn_active, exp_o, exp_a);
      end
    end
    bus.btn_abajo_raw = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      o     = outs();
      exp_a = (k < 6);
      n_asserts++;
      if (o !== 4'b1111 || bus.btn_active !== exp_a) begin
        n_fails++;
        $display("FAIL aba_release k=%0d: got outs=%b active=%b expected outs=1111 active=%b",
                 k, o, bus.btn_active, exp_a);
      end
    end
  endtask

  task automatic test_autorepeat();
    logic [3:0] o;
    logic [3:0] exp_o;
    logic       exp_a;
    logic       strobe;
    bus.btn_izquierda_raw = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      tick();
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
      strobe = (k == 7) || (k >= 15 && k <= 36 && ((k - 15) % 3) == 0);
`else
      strobe = (k == 7);
`endif
      o     = outs();
      exp_o = strobe ? 4'b1110 : 4'b1111;
      exp_a = (k >= 8) && (k <= 36);
      n_asserts++;
      if (o !== exp_o || bus.btn_active !== exp_a) begin
        n_fails++;
        $display("FAIL long_hold k=%0d: got outs=%b active=%b expected outs=%b active=%b",
                 k, o, bus.btn_active, exp_o, exp_a);
      end
      if (k == 30) bus.btn_izquierda_raw = 1'b1;
    end
  endtask

  // Sequencer and final report
  initial begin
    n_asserts = 0;
    n_fails   = 0;
    test_reset();
    test_press_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid_hold();
    test_autorepeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
